// File: rtl/sim_mon_pkg.sv
// Shared types for the sparrow_soc test-completion monitor.
// State encoding matches the state_o port.
package sim_mon_pkg;

  localparam int MON_STATE_W = 3;

  typedef enum logic [MON_STATE_W-1:0] {
    ST_RUN     = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_SW_END  = 3'd5
  } mon_state_e;

  function automatic logic is_term(input mon_state_e s);
    return (s == ST_PASS) || (s == ST_FAIL) ||
           (s == ST_TIMEOUT) || (s == ST_SW_END);
  endfunction

endpackage

// File: rtl/sim_trap_gen.sv
// One external-trap stimulus channel: registered pulse of LEN cycles
// starting at START, optionally repeating every PERIOD cycles.
module sim_trap_gen #(
  parameter int START  = 900,
  parameter int LEN    = 7,
  parameter int PERIOD = 0,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             kill_i,
  output logic             trap_o
);

  localparam logic [CNT_W-1:0] ST  = CNT_W'(START);
  localparam logic [CNT_W-1:0] LN  = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] LM1 = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0] PM1 = CNT_W'(PERIOD - 1);

  logic             run_q, run_d;
  logic [CNT_W-1:0] ph_q, ph_d;
  logic             trap_q, trap_d;

  // cnt_i is next cycle's count, so the pulse register lines up with cycle_o
  always_comb begin
    run_d = run_q;
    ph_d  = ph_q;
    if (cnt_i == ST) begin
      run_d = 1'b1;
      ph_d  = '0;
    end else if (run_q) begin
      if (PERIOD != 0 && ph_q == PM1) begin
        ph_d = '0;
      end else if (PERIOD == 0 && ph_q == LM1) begin
        run_d = 1'b0;
      end else begin
        ph_d = ph_q + 1'b1;
      end
    end
    trap_d = run_d && (ph_d < LN) && !kill_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      ph_q   <= '0;
      trap_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      ph_q   <= ph_d;
      trap_q <= trap_d;
    end
  end

  assign trap_o = trap_q;

endmodule

// File: rtl/sim_test_monitor.sv
// Test-completion monitor: shadows done/pass/testnum registers,
// reports the verdict after a settle window and drives trap stimulus.
module sim_test_monitor
  import sim_mon_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RAW          = 5,
  parameter int DONE_REG     = 26,
  parameter int PASS_REG     = 27,
  parameter int NUM_REG      = 3,
  parameter int SETTLE_CYC   = 10,
  parameter int TIMEOUT_CYC  = 30000,
  parameter int CNT_W        = 32,
  parameter int TRAP_CH      = 1,
  parameter int TRAP_START   = 900,
  parameter int TRAP_SPACING = 100,
  parameter int TRAP_LEN     = 7,
  parameter int TRAP_PERIOD  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rf_we_i,
  input  logic [RAW-1:0]         rf_waddr_i,
  input  logic [XLEN-1:0]        rf_wdata_i,
  input  logic                   mends_i,
  output logic [TRAP_CH-1:0]     ex_trap_o,
  output logic [MON_STATE_W-1:0] state_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [XLEN-1:0]        fail_num_o,
  output logic [CNT_W-1:0]       cycle_o
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0]    SL_M1 = SW'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [XLEN-1:0]  ONE   = XLEN'(1);

  mon_state_e      state_q, state_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [XLEN-1:0] done_sh_q, pass_sh_q, num_sh_q;
  logic [XLEN-1:0] fnum_q, fnum_d;
  logic            done_q, pass_q;
  logic            wr_ok, kill;

  assign cycle_d = (&cycle_q) ? cycle_q : cycle_q + 1'b1;
  assign wr_ok   = rf_we_i && (rf_waddr_i != '0) && !is_term(state_q);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    fnum_d   = fnum_q;
    unique case (state_q)
      ST_RUN: begin
        if (mends_i) begin
          state_d = ST_SW_END;
        end else if (done_sh_q == ONE) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end else if (TIMEOUT_CYC != 0 && cycle_q == TO_M1) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_SETTLE: begin
        if (mends_i) begin
          state_d = ST_SW_END;
        end else if (settle_q == SL_M1) begin
          if (pass_sh_q == ONE) begin
            state_d = ST_PASS;
          end else begin
            state_d = ST_FAIL;
            fnum_d  = num_sh_q;
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      settle_q  <= '0;
      cycle_q   <= '0;
      done_sh_q <= '0;
      pass_sh_q <= '0;
      num_sh_q  <= '0;
      fnum_q    <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      cycle_q  <= cycle_d;
      fnum_q   <= fnum_d;
      done_q   <= is_term(state_d);
      pass_q   <= (state_d == ST_PASS);
      if (wr_ok && rf_waddr_i == RAW'(DONE_REG)) done_sh_q <= rf_wdata_i;
      if (wr_ok && rf_waddr_i == RAW'(PASS_REG)) pass_sh_q <= rf_wdata_i;
      if (wr_ok && rf_waddr_i == RAW'(NUM_REG))  num_sh_q  <= rf_wdata_i;
    end
  end

  // kill looks at the next state so traps drop in the first terminal cycle
  assign kill = is_term(state_d);

  for (genvar k = 0; k < TRAP_CH; k++) begin : g_trap
    sim_trap_gen #(
      .START (TRAP_START + k * TRAP_SPACING),
      .LEN   (TRAP_LEN),
      .PERIOD(TRAP_PERIOD),
      .CNT_W (CNT_W)
    ) u_trap (
      .clk   (clk),
      .rst_n (rst_n),
      .cnt_i (cycle_d),
      .kill_i(kill),
      .trap_o(ex_trap_o[k])
    );
  end

  assign state_o    = state_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign fail_num_o = fnum_q;
  assign cycle_o    = cycle_q;

endmodule

// File: tb/tb_sim_test_monitor.sv
// Directed bench: A = 2 periodic trap channels, B = 500-cycle watchdog,
// C = watchdog disabled. "write lands at N" = shadow holds it in cycle N.
module tb_sim_test_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic        mends = 1'b0;

  logic [1:0]  trap_a;
  logic [2:0]  st_a, st_b, st_c;
  logic        dn_a, dn_b, dn_c, ps_a, ps_b, ps_c;
  logic [31:0] fn_a, fn_b, fn_c, cy_a, cy_b, cy_c;
  logic [0:0]  trap_b, trap_c;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sim_test_monitor #(.TRAP_CH(2), .TRAP_PERIOD(50)) u_a (
    .clk(clk), .rst_n(rst_n), .rf_we_i(we), .rf_waddr_i(wa),
    .rf_wdata_i(wd), .mends_i(mends), .ex_trap_o(trap_a),
    .state_o(st_a), .done_o(dn_a), .pass_o(ps_a),
    .fail_num_o(fn_a), .cycle_o(cy_a));

  sim_test_monitor #(.TIMEOUT_CYC(500)) u_b (
    .clk(clk), .rst_n(rst_n), .rf_we_i(1'b0), .rf_waddr_i(5'd0),
    .rf_wdata_i(32'd0), .mends_i(1'b0), .ex_trap_o(trap_b),
    .state_o(st_b), .done_o(dn_b), .pass_o(ps_b),
    .fail_num_o(fn_b), .cycle_o(cy_b));

  sim_test_monitor #(.TIMEOUT_CYC(0)) u_c (
    .clk(clk), .rst_n(rst_n), .rf_we_i(1'b0), .rf_waddr_i(5'd0),
    .rf_wdata_i(32'd0), .mends_i(1'b0), .ex_trap_o(trap_c),
    .state_o(st_c), .done_o(dn_c), .pass_o(ps_c),
    .fail_num_o(fn_c), .cycle_o(cy_c));

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic at(input int n);
    int guard = 0;
    while (cy_a != 32'(n) && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_cycle", 64'(cy_a), 64'(n));
  endtask

  task automatic wr(input int land, input logic [4:0] a,
                    input logic [31:0] d);
    at(land - 1);
    we = 1'b1; wa = a; wd = d;
    @(negedge clk);
    we = 1'b0; wa = '0; wd = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    check("rst_state", 64'(st_a), 64'd0);
    check("rst_cycle", 64'(cy_a), 64'd0);
    check("rst_done", 64'(dn_a), 64'd0);
    check("rst_pass", 64'(ps_a), 64'd0);
    check("rst_fnum", 64'(fn_a), 64'd0);
    check("rst_trap", 64'(trap_a), 64'd0);
    check("rst_state_b", 64'(st_b), 64'd0);

    at(499);
    check("to_b_run", 64'(st_b), 64'd0);
    at(500);
    check("to_b_state", 64'(st_b), 64'd4);
    check("to_b_cycle", 64'(cy_b), 64'd500);
    check("to_b_done", 64'(dn_b), 64'd1);
    check("to_b_pass", 64'(ps_b), 64'd0);

    at(899);
    check("trap_899", 64'(trap_a), 64'd0);
    at(900);
    check("trap_900", 64'(trap_a), 64'd1);
    check("trap_b_killed", 64'(trap_b), 64'd0);
    check("trap_c_900", 64'(trap_c), 64'd1);
    at(906);
    check("trap_906", 64'(trap_a), 64'd1);
    at(907);
    check("trap_907", 64'(trap_a), 64'd0);
    check("trap_c_907", 64'(trap_c), 64'd0);
    at(950);
    check("trap_950", 64'(trap_a), 64'd1);
    check("trap_c_oneshot", 64'(trap_c), 64'd0);
    at(956);
    check("trap_956", 64'(trap_a), 64'd1);
    at(957);
    check("trap_957", 64'(trap_a), 64'd0);
    at(999);
    check("trap_999", 64'(trap_a), 64'd0);
    at(1000);
    check("trap_1000", 64'(trap_a), 64'd3);
    at(1006);
    check("trap_1006", 64'(trap_a), 64'd3);
    at(1007);
    check("trap_1007", 64'(trap_a), 64'd0);

    wr(1100, 5'd27, 32'd1);
    wr(1200, 5'd26, 32'd1);
    check("a_1200_run", 64'(st_a), 64'd0);
    at(1211);
    check("a_pass", 64'(st_a), 64'd2);
    check("a_pass_trap", 64'(trap_a), 64'd0);
    at(1250);
    check("killed_1250", 64'(trap_a), 64'd0);
    at(1253);
    check("killed_1253", 64'(trap_a), 64'd0);
    at(5000);
    check("c_run_5000", 64'(st_c), 64'd0);
    check("c_done_5000", 64'(dn_c), 64'd0);
    check("b_sticky", 64'(st_b), 64'd4);

    do_reset();
    wr(195, 5'd27, 32'd1);
    wr(200, 5'd26, 32'd1);
    check("p_200", 64'(st_a), 64'd0);
    at(201);
    check("p_201", 64'(st_a), 64'd1);
    at(210);
    check("p_210", 64'(st_a), 64'd1);
    check("p_210_pass", 64'(ps_a), 64'd0);
    at(211);
    check("p_211", 64'(st_a), 64'd2);
    check("p_done", 64'(dn_a), 64'd1);
    check("p_pass", 64'(ps_a), 64'd1);

    do_reset();
    wr(100, 5'd3, 32'd5);
    wr(200, 5'd26, 32'd1);
    at(210);
    check("f_210", 64'(st_a), 64'd1);
    at(211);
    check("f_state", 64'(st_a), 64'd3);
    check("f_num", 64'(fn_a), 64'd5);
    check("f_pass", 64'(ps_a), 64'd0);
    check("f_done", 64'(dn_a), 64'd1);
    wr(220, 5'd27, 32'd1);
    wr(221, 5'd3, 32'd9);
    at(225);
    check("f_sticky", 64'(st_a), 64'd3);
    check("f_num_hold", 64'(fn_a), 64'd5);

    do_reset();
    wr(200, 5'd26, 32'd1);
    wr(205, 5'd27, 32'd1);
    at(211);
    check("late_pass", 64'(st_a), 64'd2);

    do_reset();
    at(99);
    we = 1'b1; wa = 5'd26; wd = 32'd1; mends = 1'b1;
    @(negedge clk);
    we = 1'b0; wa = '0; wd = '0; mends = 1'b0;
    check("swend_state", 64'(st_a), 64'd5);
    check("swend_done", 64'(dn_a), 64'd1);
    check("swend_pass", 64'(ps_a), 64'd0);
    wr(110, 5'd27, 32'd1);
    at(120);
    check("swend_sticky", 64'(st_a), 64'd5);

    do_reset();
    at(902);
    check("mid_trap_on", 64'(trap_a), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_trap_cut", 64'(trap_a), 64'd0);
    check("mid_cycle", 64'(cy_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sim_test_monitor.md
Name: sim_test_monitor

Overview:
- Synthesizable test-completion monitor for sparrow_soc, replacing hard-coded bench checks with one parametrised block. Usable in simulation and on FPGA.
- Snoops the core register-file write port and shadows the done, pass and testnum registers. Applies a settle window, then reports PASS/FAIL/TIMEOUT/SW_END; also watches the CSR mends flag.
- Drives a configurable number of external-trap stimulus channels, one-shot or periodic.

Parameters:
- XLEN, 32, register data width
- RAW, 5, register address width
- DONE_REG, 26, index of done-flag register (nonzero)
- PASS_REG, 27, index of pass-flag register (nonzero)
- NUM_REG, 3, index of test-number register (nonzero)
- SETTLE_CYC, 10, cycles between done detection and pass sampling (>=1)
- TIMEOUT_CYC, 30000, watchdog limit in cycles; 0 disables the watchdog
- CNT_W, 32, cycle counter width
- TRAP_CH, 1, number of trap channels (1..8)
- TRAP_START, 900, first assertion cycle of channel 0
- TRAP_SPACING, 100, start offset added per channel index
- TRAP_LEN, 7, pulse length in cycles (>=1)
- TRAP_PERIOD, 0, 0 = one-shot; otherwise repeat period (must be > TRAP_LEN)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rf_we_i  in  1  register-file write enable
- rf_waddr_i  in  RAW  write address
- rf_wdata_i  in  XLEN  write data
- mends_i  in  1  software end-of-simulation flag from CSR
- ex_trap_o  out  TRAP_CH  trap stimulus, one bit per channel
- state_o  out  3  0 RUN, 1 SETTLE, 2 PASS, 3 FAIL, 4 TIMEOUT, 5 SW_END
- done_o  out  1  high in any terminal state
- pass_o  out  1  high only in PASS
- fail_num_o  out  XLEN  test-number shadow captured on the FAIL transition
- cycle_o  out  CNT_W  cycles since reset release

Behaviour:
- Reset: all outputs 0, state RUN, all shadows 0, counters 0.
- Shadows: on rf_we_i with rf_waddr_i equal to DONE_REG, PASS_REG or NUM_REG, the matching shadow loads rf_wdata_i. The updated value is visible to the FSM the next cycle. Writes to index 0 are ignored.
- cycle_o: increments every cycle after reset release; saturates at all-ones and never wraps. It keeps counting in terminal states.
- RUN:
  - mends_i high -> SW_END.
  - Else done shadow == 1 -> SETTLE, settle counter cleared.
  - Else TIMEOUT_CYC != 0 and cycle_o == TIMEOUT_CYC-1 -> TIMEOUT.
  - Priority is mends > done > timeout.
- SETTLE:
  - Counts SETTLE_CYC cycles; writes to the shadows continue to update them.
  - mends_i -> SW_END. The watchdog does not apply in SETTLE.
  - On the last settle cycle: pass shadow == 1 -> PASS, else FAIL and fail_num_o <= NUM shadow.
  - Done detection to terminal state takes exactly SETTLE_CYC+1 cycles.
- Terminal states: sticky until reset. Later writes and mends_i are ignored. done_o, pass_o and fail_num_o are registered and hold stable.
- Trap channel k:
  - Start cycle S_k = TRAP_START + k*TRAP_SPACING.
  - ex_trap_o[k] is high for cycle_o in [S_k, S_k+TRAP_LEN-1].
  - If TRAP_PERIOD != 0, the pulse repeats every TRAP_PERIOD cycles.
  - All channels are forced to 0 in terminal states.
  - Outputs are registered and glitch-free.
- Reset asserted mid-operation: everything returns to reset values immediately. Any active trap pulse is truncated.

Decomposition:
- Package sim_mon_pkg holds:
  - state enum mon_state_e (RUN, SETTLE, PASS, FAIL, TIMEOUT, SW_END, 3-bit encoding as in state_o)
  - localparam MON_STATE_W = 3
- One sub-module, sim_trap_gen, holds the per-channel pulse timing, instantiated via generate over TRAP_CH. Parameters: START, LEN, PERIOD, CNT_W. Inputs: cycle count and kill. Output: trap bit.
- The FSM, shadows and counter live in sim_test_monitor.

Test Plan:
- Write x26=1 at cycle 200, with x27=1 written at cycle 195 -> state SETTLE at cycle 201, PASS at cycle 211; done_o=1, pass_o=1.
- Write x3=5, then x26=1, and never write x27 -> FAIL after SETTLE_CYC+1 cycles; fail_num_o=5, pass_o=0.
- Write x27=1 at cycle 205, during the settle window after x26=1 at cycle 200 -> PASS (late pass write honoured).
- No writes, TIMEOUT_CYC=500 -> TIMEOUT with cycle_o=500 the following cycle. Repeat with TIMEOUT_CYC=0 -> stays RUN at cycle 5000.
- mends_i and a done write in the same cycle -> SW_END; a later x27=1 write -> state unchanged.
- TRAP_CH=2, TRAP_SPACING=100, TRAP_PERIOD=50:
  - ex_trap_o[0] high for cycles 900-906 and 950-956.
  - ex_trap_o[1] high for cycles 1000-1006.
  - After reaching PASS, ex_trap_o stays 0.
  - Reset pulsed during a pulse clears it within the same cycle.
